// File: rtl/nn_pkg.sv
// Shared neural-network datapath constants and the ReLU derivative rule,
// reused by the forward ReLU, this backward gate and future leaky/clipped variants.
package nn_pkg;

    localparam int unsigned NN_DATA_W = 8;
    localparam int unsigned IS_POS_W  = 32;

    // Callers sign-extend narrower values; zero counts as non-positive, so d/dx at 0 is 0.
    function automatic logic is_pos(input logic signed [IS_POS_W-1:0] x);
        return x > 0;
    endfunction

endpackage

// File: rtl/relu_backprop_gate_bit_fifo.sv
// In-order 1-bit FIFO holding ReLU derivative masks between the forward and backward passes.
module bit_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             din,
    input  logic             pop,
    output logic             dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_en;
    logic             pop_en;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    // No bypass: full blocks push and empty blocks pop regardless of the other side.
    assign push_en = push && !full && !flush;
    assign pop_en  = pop && !empty && !flush;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_en && !pop_en) begin
                count <= count + CNT_W'(1);
            end else if (pop_en && !push_en) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/relu_backprop_gate.sv
// Backward ReLU gate: passes each gradient where the recorded forward input was
// strictly positive, else zero, with a one-deep registered output stage.
module relu_backprop_gate
    import nn_pkg::*;
#(
    parameter int unsigned DATA_W = NN_DATA_W,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              fwd_valid,
    output logic              fwd_ready,
    input  logic [DATA_W-1:0] fwd_data,
    input  logic              grad_in_valid,
    output logic              grad_in_ready,
    input  logic [DATA_W-1:0] grad_in_data,
    output logic              grad_out_valid,
    input  logic              grad_out_ready,
    output logic [DATA_W-1:0] grad_out_data,
    output logic [CNT_W-1:0]  mask_count,
    output logic              mask_full,
    output logic              mask_empty
);

    logic push;
    logic accept;
    logic mask_in;
    logic mask_head;

    assign mask_in       = is_pos(IS_POS_W'($signed(fwd_data)));
    assign fwd_ready     = !mask_full;
    assign grad_in_ready = !mask_empty && (!grad_out_valid || grad_out_ready);
    assign push          = fwd_valid && fwd_ready;
    assign accept        = grad_in_valid && grad_in_ready;

    bit_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_mask_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .din   (mask_in),
        .pop   (accept),
        .dout  (mask_head),
        .count (mask_count),
        .full  (mask_full),
        .empty (mask_empty)
    );

    // Data is left untouched when the stage drains or flushes; only valid drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grad_out_valid <= 1'b0;
            grad_out_data  <= '0;
        end else if (flush) begin
            grad_out_valid <= 1'b0;
        end else if (accept) begin
            grad_out_valid <= 1'b1;
            grad_out_data  <= mask_head ? grad_in_data : '0;
        end else if (grad_out_ready) begin
            grad_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_relu_backprop_gate.sv
// Directed bench for relu_backprop_gate with a mask/expected-output scoreboard.
module tb_relu_backprop_gate;

    localparam int DW = 8;
    localparam int D  = 16;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          fwd_valid;
    logic          fwd_ready;
    logic [DW-1:0] fwd_data;
    logic          grad_in_valid;
    logic          grad_in_ready;
    logic [DW-1:0] grad_in_data;
    logic          grad_out_valid;
    logic          grad_out_ready;
    logic [DW-1:0] grad_out_data;
    logic [CW-1:0] mask_count;
    logic          mask_full;
    logic          mask_empty;

    int n_cmp = 0;
    int n_err = 0;

    bit            mask_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] seen_q[$];
    bit            m_valid = 1'b0;

    always #5 clk = ~clk;

    relu_backprop_gate #(
        .DATA_W (DW),
        .DEPTH  (D),
        .CNT_W  (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .fwd_valid      (fwd_valid),
        .fwd_ready      (fwd_ready),
        .fwd_data       (fwd_data),
        .grad_in_valid  (grad_in_valid),
        .grad_in_ready  (grad_in_ready),
        .grad_in_data   (grad_in_data),
        .grad_out_valid (grad_out_valid),
        .grad_out_ready (grad_out_ready),
        .grad_out_data  (grad_out_data),
        .mask_count     (mask_count),
        .mask_full      (mask_full),
        .mask_empty     (mask_empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic idle();
        flush          = 1'b0;
        fwd_valid      = 1'b0;
        fwd_data       = '0;
        grad_in_valid  = 1'b0;
        grad_in_data   = '0;
        grad_out_ready = 1'b1;
    endtask

    task automatic clear_model();
        mask_q.delete();
        exp_q.delete();
        m_valid = 1'b0;
    endtask

    // One clock: check handshakes, advance the scoreboard, then check state after the edge.
    task automatic tick();
        int            cnt;
        bit            acc;
        bit            psh;
        logic [DW-1:0] e;
        #1;
        cnt = mask_q.size();
        acc = grad_in_valid && (cnt > 0) && (!m_valid || grad_out_ready);
        psh = fwd_valid && (cnt < D);
        chk("fwd_ready", {31'd0, fwd_ready}, {31'd0, cnt < D});
        chk("grad_in_ready", {31'd0, grad_in_ready},
            {31'd0, (cnt > 0) && (!m_valid || grad_out_ready)});
        if (grad_out_valid && grad_out_ready) seen_q.push_back(grad_out_data);
        if (m_valid && grad_out_ready) void'(exp_q.pop_front());
        if (flush) begin
            clear_model();
        end else begin
            if (acc) begin
                e = mask_q.pop_front() ? grad_in_data : '0;
                exp_q.push_back(e);
                m_valid = 1'b1;
            end else if (grad_out_ready) begin
                m_valid = 1'b0;
            end
            if (psh) mask_q.push_back(fwd_data != 0 && !fwd_data[DW-1]);
        end
        @(posedge clk);
        #1;
        chk("mask_count", 32'(mask_count), 32'(mask_q.size()));
        chk("grad_out_valid", {31'd0, grad_out_valid}, {31'd0, m_valid});
        chk("mask_empty", {31'd0, mask_empty}, {31'd0, mask_q.size() == 0});
        chk("mask_full", {31'd0, mask_full}, {31'd0, mask_q.size() == D});
        if (m_valid) chk("grad_out_data", 32'(grad_out_data), 32'(exp_q[0]));
    endtask

    task automatic push_val(input logic [DW-1:0] v);
        idle();
        fwd_valid = 1'b1;
        fwd_data  = v;
        tick();
    endtask

    task automatic grad_val(input logic [DW-1:0] g);
        idle();
        grad_in_valid = 1'b1;
        grad_in_data  = g;
        tick();
    endtask

    task automatic check_seen(input string tag, input logic [DW-1:0] v);
        if (seen_q.size() == 0) begin
            chk({tag, "_missing"}, 32'd0, 32'd1);
        end else begin
            chk(tag, 32'(seen_q.pop_front()), 32'(v));
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_count", 32'(mask_count), 32'd0);
        chk("rst_empty", {31'd0, mask_empty}, 32'd1);
        chk("rst_full", {31'd0, mask_full}, 32'd0);
        chk("rst_valid", {31'd0, grad_out_valid}, 32'd0);
        chk("rst_data", 32'(grad_out_data), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_fwd_ready", {31'd0, fwd_ready}, 32'd1);
        chk("rst_grad_in_ready", {31'd0, grad_in_ready}, 32'd0);

        // Mask rule: positive, negative, zero, max positive.
        seen_q.delete();
        push_val(8'h05);
        push_val(8'hFB);
        push_val(8'h00);
        push_val(8'h7F);
        chk("seq_count4", 32'(mask_count), 32'd4);
        grad_val(8'h10);
        chk("seq_lat1_data", 32'(grad_out_data), 32'h10);
        grad_val(8'h20);
        grad_val(8'hF0);
        grad_val(8'h81);
        idle();
        tick();
        check_seen("seq0", 8'h10);
        check_seen("seq1", 8'h00);
        check_seen("seq2", 8'h00);
        check_seen("seq3", 8'h81);
        chk("seq_count0", 32'(mask_count), 32'd0);

        // Fill to full, refuse a 17th, pop one.
        for (int i = 0; i < D; i++) push_val(8'(i + 1));
        chk("full_flag", {31'd0, mask_full}, 32'd1);
        chk("full_count", 32'(mask_count), 32'd16);
        chk("full_fwd_ready", {31'd0, fwd_ready}, 32'd0);
        push_val(8'h33);
        chk("refused_count", 32'(mask_count), 32'd16);
        grad_val(8'h44);
        chk("pop_count15", 32'(mask_count), 32'd15);
        chk("pop_fwd_ready", {31'd0, fwd_ready}, 32'd1);
        push_val(8'h01);
        idle();
        fwd_valid = 1'b1;
        fwd_data = 8'h02;
        grad_in_valid = 1'b1;
        grad_in_data = 8'h55;
        tick();
        chk("full_pushpop_count", 32'(mask_count), 32'd15);
        for (int i = 0; i < 7; i++) grad_val(8'(8'h60 + i));
        chk("mid_count8", 32'(mask_count), 32'd8);
        idle();
        fwd_valid = 1'b1;
        fwd_data = 8'h03;
        grad_in_valid = 1'b1;
        grad_in_data = 8'h70;
        tick();
        chk("mid_pushpop_count", 32'(mask_count), 32'd8);
        for (int i = 0; i < 20 && mask_q.size() > 0; i++) grad_val(8'(8'h40 + i));
        idle();
        tick();
        chk("drained", {31'd0, mask_empty}, 32'd1);

        // Gradient against an empty FIFO, then push followed by gradient.
        grad_val(8'h11);
        chk("empty_no_out", {31'd0, grad_out_valid}, 32'd0);
        push_val(8'h09);
        grad_val(8'h12);
        chk("after_push_out", 32'(grad_out_data), 32'h12);
        idle();
        tick();

        // Backpressure for three cycles on a valid 8'h22.
        seen_q.delete();
        push_val(8'h01);
        push_val(8'h01);
        grad_val(8'h22);
        for (int i = 0; i < 3; i++) begin
            idle();
            grad_in_valid = 1'b1;
            grad_in_data = 8'h33;
            grad_out_ready = 1'b0;
            tick();
            chk("bp_hold_data", 32'(grad_out_data), 32'h22);
            chk("bp_no_pop", 32'(mask_count), 32'd1);
        end
        grad_val(8'h33);
        idle();
        tick();
        check_seen("bp0", 8'h22);
        check_seen("bp1", 8'h33);
        chk("bp_no_dup", 32'(seen_q.size()), 32'd0);

        // Mixed traffic across pointer wrap.
        for (int i = 0; i < 40; i++) begin
            idle();
            fwd_valid = 1'($urandom_range(0, 1));
            fwd_data = 8'($urandom);
            grad_in_valid = 1'($urandom_range(0, 1));
            grad_in_data = 8'($urandom);
            grad_out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        for (int i = 0; i < 20 && (mask_q.size() > 0 || m_valid); i++) grad_val(8'(8'hA0 + i));
        idle();
        tick();

        // Flush with count 5 and a valid output, while a forward item is offered.
        for (int i = 0; i < 6; i++) push_val(8'h10);
        grad_val(8'h77);
        chk("pre_flush_count", 32'(mask_count), 32'd5);
        idle();
        flush = 1'b1;
        fwd_valid = 1'b1;
        fwd_data = 8'h05;
        tick();
        chk("flush_count", 32'(mask_count), 32'd0);
        chk("flush_empty", {31'd0, mask_empty}, 32'd1);
        chk("flush_valid", {31'd0, grad_out_valid}, 32'd0);
        idle();
        tick();

        // Asynchronous reset mid-stream.
        push_val(8'h01);
        push_val(8'h02);
        push_val(8'h03);
        grad_val(8'h5A);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(mask_count), 32'd0);
        chk("arst_empty", {31'd0, mask_empty}, 32'd1);
        chk("arst_valid", {31'd0, grad_out_valid}, 32'd0);
        chk("arst_data", 32'(grad_out_data), 32'd0);
        clear_model();
        rst = 1'b0;
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
